alu_6b: RTL and testbench

- Small registered ALU operating on two's-complement operands of WIDTH bits (default 6).
- Supports add, subtract, bitwise AND/OR, equality, signed greater-than, signed less-than and zero-test of A.
- A 3-bit opcode selects the operation.
- Result and status flags are registered on the single clock with one-cycle latency; used as the datapath execute stage.

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_addsub.sv | 27 ++
 rtl/alu_6b.sv | 91 +++++++++
 tb/tb_alu_6b.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encoding and default width
// for the registered execute-stage ALU.
package alu_pkg;

  localparam int ALU_WIDTH = 6;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_EQ   = 3'b100,
    OP_GT   = 3'b101,
    OP_LT   = 3'b110,
    OP_ZERO = 3'b111
  } alu_op_e;

endpackage

// File: rtl/alu_addsub.sv
// Single shared adder; subtract is a + ~b + 1.
// Used by ADD, SUB and the signed compares.
module alu_addsub #(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf
);

  logic [WIDTH-1:0] w_b;
  logic [WIDTH:0]   w_full;

  assign w_b    = sub ? ~b : b;
  assign w_full = {1'b0, a} + {1'b0, w_b}
                + {{WIDTH{1'b0}}, sub};
  assign sum    = w_full[WIDTH-1:0];
  assign carry  = w_full[WIDTH];

  // Overflow: same-sign addends, result sign differs
  assign ovf = (a[WIDTH-1] == w_b[WIDTH-1])
            && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu_6b.sv
// Registered ALU execute stage: result and
// flags appear one clock after operands.
module alu_6b
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       sel,
  output logic [WIDTH-1:0] C,
  output logic             ovf,
  output logic             zero
);

  logic             w_sub;
  logic [WIDTH-1:0] w_sum;
  logic             w_carry;
  logic             w_aovf;
  logic             w_eq;
  logic             w_lt;
  logic             w_gt;
  logic [WIDTH-1:0] w_c;
  logic             w_ovf;

  logic [WIDTH-1:0] r_c;
  logic             r_ovf;
  logic             r_zero;

  assign w_sub = (sel != OP_ADD);

  alu_addsub #(
    .WIDTH (WIDTH)
  ) u_addsub (
    .a     (A),
    .b     (B),
    .sub   (w_sub),
    .sum   (w_sum),
    .carry (w_carry),
    .ovf   (w_aovf)
  );

  // Compares reuse the subtractor result
  assign w_lt = w_sum[WIDTH-1] ^ w_aovf;
  assign w_eq = (w_sum == '0);
  assign w_gt = !w_lt && !w_eq;

  always_comb begin
    w_c   = '0;
    w_ovf = 1'b0;
    case (alu_op_e'(sel))
      OP_ADD: begin
        w_c   = w_sum;
        w_ovf = w_aovf;
      end
      OP_SUB: begin
        w_c   = w_sum;
        w_ovf = w_aovf;
      end
      OP_AND:  w_c = A & B;
      OP_OR:   w_c = A | B;
      OP_EQ:   w_c = WIDTH'(w_eq);
      OP_GT:   w_c = WIDTH'(w_gt);
      OP_LT:   w_c = WIDTH'(w_lt);
      OP_ZERO: w_c = WIDTH'(A == '0);
      default: w_c = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c    <= '0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b1;
    end else begin
      r_c    <= w_c;
      r_ovf  <= w_ovf;
      r_zero <= (w_c == '0);
    end
  end

  assign C    = r_c;
  assign ovf  = r_ovf;
  assign zero = r_zero;

  logic w_unused;
  assign w_unused = w_carry;

endmodule

// File: tb/tb_alu_6b.sv
// Directed and random checks of alu_6b against
// an integer-arithmetic reference model.
module tb_alu_6b;

  localparam int W = 6;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [2:0]   sel;
  logic [W-1:0] C;
  logic         ovf;
  logic         zero;

  int nasrt;
  int nfail;
  logic [W-1:0] last_c;

  alu_6b #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .sel   (sel),
    .C     (C),
    .ovf   (ovf),
    .zero  (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sval(input int v);
    return (v > 31) ? v - 64 : v;
  endfunction

  // Returns {zero, ovf, C}
  function automatic logic [7:0] model(
    input int a, input int b, input int s);
    int sa, sb, r;
    int c;
    logic o;
    logic [W-1:0] cb;
    sa = sval(a);
    sb = sval(b);
    o  = 1'b0;
    c  = 0;
    case (s)
      0: begin
        r = sa + sb;
        o = (r > 31) || (r < -32);
        c = r;
      end
      1: begin
        r = sa - sb;
        o = (r > 31) || (r < -32);
        c = r;
      end
      2: c = a & b;
      3: c = a | b;
      4: c = (a == b) ? 1 : 0;
      5: c = (sa > sb) ? 1 : 0;
      6: c = (sa < sb) ? 1 : 0;
      default: c = (a == 0) ? 1 : 0;
    endcase
    cb = c[W-1:0];
    return {(cb == '0), o, cb};
  endfunction

  task automatic chk(input string tag,
    input logic [W-1:0] ec,
    input logic eo, input logic ez);
    nasrt++;
    assert (C === ec) else begin
      nfail++;
      $error("FAIL %s C: got %b want %b",
        tag, C, ec);
    end
    nasrt++;
    assert (ovf === eo) else begin
      nfail++;
      $error("FAIL %s ovf: got %b want %b",
        tag, ovf, eo);
    end
    nasrt++;
    assert (zero === ez) else begin
      nfail++;
      $error("FAIL %s zero: got %b want %b",
        tag, zero, ez);
    end
    last_c = ec;
  endtask

  // Drive at negedge, confirm output holds until
  // the next rising edge, then let it capture.
  task automatic run(input string tag,
    input int a, input int b, input int s);
    @(negedge clk);
    A   = a[W-1:0];
    B   = b[W-1:0];
    sel = s[2:0];
    #1;
    nasrt++;
    assert (C === last_c) else begin
      nfail++;
      $error("FAIL %s hold: got %b want %b",
        tag, C, last_c);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic dir(input string tag,
    input int a, input int b, input int s,
    input int ec, input logic eo);
    logic [W-1:0] e;
    e = ec[W-1:0];
    run(tag, a, b, s);
    chk(tag, e, eo, (e == '0));
  endtask

  task automatic mdl(input string tag,
    input int a, input int b, input int s);
    logic [7:0] m;
    m = model(a, b, s);
    run(tag, a, b, s);
    chk(tag, m[W-1:0], m[6], m[7]);
  endtask

  int pa [7];
  int pb [7];
  int eeq [7];
  int egt [7];
  int elt [7];

  initial begin
    nasrt  = 0;
    nfail  = 0;
    last_c = '0;
    rst_n  = 1'b0;
    A      = '0;
    B      = '0;
    sel    = '0;
    #12;
    chk("rst_init", 6'd0, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    dir("pre_rst", 5, 10, 0, 15, 1'b0);
    // Async reset mid-cycle
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async", 6'd0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    chk("rst_hold", 6'd0, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_rel", 6'd15, 1'b0, 1'b0);

    dir("add0", 5, 10, 0, 15, 1'b0);
    dir("add1", -5, -14, 0, -19, 1'b0);
    dir("add2", 31, 15, 0, 46, 1'b1);
    dir("add3", -31, -12, 0, 21, 1'b1);
    dir("add4", 0, 17, 0, 17, 1'b0);
    dir("sub0", 16, 1, 1, 15, 1'b0);
    dir("sub1", 16, -18, 1, 34, 1'b1);
    dir("sub2", -15, -16, 1, 1, 1'b0);
    dir("sub3", 0, 1, 1, 63, 1'b0);
    dir("sub4", -31, 5, 1, 28, 1'b1);
    dir("and", 42, 51, 2, 34, 1'b0);
    dir("or", 42, 51, 3, 59, 1'b0);

    pa = '{5, 2, 13, -15, 19, -3, -25};
    pb = '{3, 15, -24, 15, 19, -10, -4};
    eeq = '{0, 0, 0, 0, 1, 0, 0};
    egt = '{1, 0, 1, 0, 0, 1, 0};
    elt = '{0, 1, 0, 1, 0, 0, 1};
    for (int i = 0; i < 7; i++) begin
      dir("eq", pa[i], pb[i], 4, eeq[i], 1'b0);
      dir("gt", pa[i], pb[i], 5, egt[i], 1'b0);
      dir("lt", pa[i], pb[i], 6, elt[i], 1'b0);
    end
    dir("eq_neg", -15, -15, 4, 1, 1'b0);

    for (int a = 0; a < 64; a++) begin
      dir("ztest", a, int'($urandom_range(0, 63)),
        7, (a == 0) ? 1 : 0, 1'b0);
    end

    for (int i = 0; i < 300; i++) begin
      mdl("rand", int'($urandom_range(0, 63)),
        int'($urandom_range(0, 63)),
        int'($urandom_range(0, 7)));
    end

    $display(
      "End of test - %0d assertions evaluated, %0d failures",
      nasrt, nfail);
    $finish;
  end

endmodule
